cnt_capture_fifo: RTL and testbench
===================================

# cnt_capture_fifo

Timestamp capture stage sitting directly downstream of the free-running counter. On each rising edge of a trigger input it samples the counter value, stores it in a small first-word-fall-through FIFO and presents stored timestamps to the consumer over a valid/ready handshake. Lost captures are reported through a sticky overflow flag.

## Interface

- WIDTH, 8, width of the counter value and of each stored timestamp
- DEPTH, 4, FIFO entries; must be a power of two, at least 2
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0); one clock, async active-low reset
- cnt_i  input  WIDTH  counter value from the upstream counter stage
- trig_i  input  1  capture request, synchronous to clk; level input, rising edge captures
- ts_o  output  WIDTH  timestamp at FIFO head; 0 when valid_o is 0
- valid_o  output  1  FIFO non-empty, ts_o holds a valid entry
- ready_i  input  1  consumer accepts ts_o this cycle
- level_o  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- overflow_o  output  1  sticky; a capture was dropped because the FIFO was full
- clr_ovf_i  input  1  synchronous clear of overflow_o

## Operation

- Edge detect: register trig_q holds the previous trig_i value. Capture request = trig_i & ~trig_q, evaluated combinationally each cycle.
- trig_q resets to 1, so a trigger held high through reset release does not produce a capture. The first capture needs a 0 then 1 on trig_i.
- Push: on a capture request the value of cnt_i in that same cycle is written at the write pointer.
- Pop: occurs when valid_o & ready_i. The read pointer advances and the next entry, if any, appears on ts_o in the following cycle.
- Pointers: log2(DEPTH)-bit read and write pointers wrap modulo DEPTH. level_o is held as a separate register or derived from extended pointers; either way it must equal pushes minus pops.
- Full, push without pop: the sample is dropped, pointers and level are unchanged, and overflow_o is set.
- Full, push with pop: both are performed and level_o stays DEPTH. This is not an overflow.
- Empty, push with pop: not possible, because valid_o is 0 when empty. The push is performed normally.
- Overflow clear: clr_ovf_i clears overflow_o. If clr_ovf_i and a new drop occur in the same cycle, overflow_o stays 1 (set wins).
- Counter values are stored verbatim, with no wrap-around handling. A timestamp of 0 after 2^WIDTH-1 is a legal entry.
- Reset: asserting reset at any time, including mid-transfer, empties the FIFO immediately and asynchronously.
- Reset values: valid_o=0, ts_o=0, level_o=0, overflow_o=0, both pointers 0, trig_q=1.
- Storage contents need no reset.

## Timing

- Capture latency is 1 cycle. If a capture request is seen in cycle N (edge sampled at the end of N), then from cycle N+1 valid_o=1, ts_o holds cnt_i(N) if the FIFO was empty, and level_o is incremented.
- Back-to-back triggers cannot occur faster than every 2 cycles, because a rising edge needs a low cycle between captures.
- Pop takes effect at the clock edge ending the cycle where valid_o & ready_i. From the next cycle ts_o, valid_o and level_o reflect the new head.
- ready_i may be held high permanently, which gives single-entry throughput.
- valid_o, once high, stays high until the entry is popped or reset is asserted. ts_o is stable while valid_o=1 and ready_i=0.
- overflow_o rises 1 cycle after the dropped capture request.
- clr_ovf_i lowers overflow_o 1 cycle after it is asserted.
- All outputs are registered or decoded only from registers; there is no combinational path from the inputs to valid_o, ts_o, level_o or overflow_o.
- Deassertion of reset is synchronous to the bench clock. The block makes no synchroniser assumption beyond that.

## Test plan

- Reset behaviour: hold trig_i=1 through reset release with cnt_i=8'h10 -> no capture, valid_o=0 and level_o=0 until trig_i goes 0 then 1.
- Single capture: ramp cnt_i, pulse trig_i high when cnt_i=8'h2A, ready_i=0 -> next cycle valid_o=1, ts_o=8'h2A, level_o=1; then ready_i=1 for 1 cycle -> valid_o=0, ts_o=0.
- Fill and overflow (DEPTH=4): capture at cnt_i=1,3,5,7,9 with ready_i=0 -> level_o=4, overflow_o=1 one cycle after the 5th request; popping returns 1,3,5,7 in order, and 9 is lost.
- Full with simultaneous push and pop: FIFO holds 4 entries, trigger at cnt_i=8'h50 in the same cycle as a pop -> level_o stays 4, overflow_o stays 0, 8'h50 is the last entry popped.
- Clear collision: overflow_o=1, assert clr_ovf_i in the same cycle as a dropped capture -> overflow_o remains 1; assert clr_ovf_i alone next -> overflow_o=0.
- Wrap and reset mid-operation: capture cnt_i=8'hFF then 8'h00 and pop both -> 8'hFF then 8'h00. With 2 entries stored, assert reset mid-cycle -> valid_o=0 and level_o=0 immediately; after release a new capture of 8'h33 is the only entry.

Source files
------------

// File: rtl/cnt_capture_fifo.sv
// Purpose: samples cnt_i on each rising edge of trig_i into a small FWFT FIFO and
//          presents the timestamps to a consumer over valid/ready.
// Latency: 1 cycle from capture request to entry visible on ts_o/valid_o.
// Backpressure: ready_i low holds the head entry stable; a capture arriving while
//               full without a simultaneous pop is dropped and sets sticky overflow_o.
//
// Ports:
//   clk        - single clock, rising-edge state updates
//   reset      - asynchronous active-low reset; empties the FIFO immediately
//   cnt_i      - counter value to be captured
//   trig_i     - level capture request; a 0->1 transition captures cnt_i
//   ts_o       - timestamp at FIFO head, 0 when valid_o is 0
//   valid_o    - FIFO non-empty
//   ready_i    - consumer accepts ts_o this cycle
//   level_o    - number of stored entries, 0..DEPTH
//   overflow_o - sticky flag: a capture was dropped because the FIFO was full
//   clr_ovf_i  - synchronous clear of overflow_o (a same-cycle drop wins)

module cnt_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           cnt_i,
    input  logic                       trig_i,
    output logic [WIDTH-1:0]           ts_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic             trig_q,   trig_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             ovf_q,    ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic cap_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    always_comb begin
        cap_req  = trig_i & ~trig_q;
        pop      = valid_o & ready_i;
        full     = (level_q == LW'(DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok  = cap_req & (~full | pop);
        drop     = cap_req & full & ~pop;

        trig_d   = trig_i;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop);

        // Set has priority over clear so a drop coinciding with a clear is not lost.
        ovf_d = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // trig_q resets high so a trigger held through reset release is not a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            trig_q   <= trig_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is qualified by level/pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cnt_i;
        end
    end

    always_comb begin
        valid_o    = (level_q != '0);
        ts_o       = valid_o ? mem_q[rd_ptr_q] : '0;
        level_o    = level_q;
        overflow_o = ovf_q;
    end

endmodule

// File: tb/tb_cnt_capture_fifo.sv
module tb_cnt_capture_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] cnt_i;
    logic       trig_i;
    logic [7:0] ts_o;
    logic       valid_o;
    logic       ready_i;
    logic [2:0] level_o;
    logic       overflow_o;
    logic       clr_ovf_i;

    int checks   = 0;
    int failures = 0;

    cnt_capture_fifo #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_i      (cnt_i),
        .trig_i     (trig_i),
        .ts_o       (ts_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .clr_ovf_i  (clr_ovf_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] v);
        cnt_i  = v;
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(valid_o), 32'd1);
        chk({tag, "_ts"},  32'(ts_o),    32'(exp));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        cnt_i     = 8'h10;
        trig_i    = 1'b1;
        ready_i   = 1'b0;
        clr_ovf_i = 1'b0;

        // Reset with trigger held high
        tick();
        tick();
        chk("rst_vld",  32'(valid_o),    32'd0);
        chk("rst_ts",   32'(ts_o),       32'd0);
        chk("rst_lvl",  32'(level_o),    32'd0);
        chk("rst_ovf",  32'(overflow_o), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("held_trig_vld", 32'(valid_o), 32'd0);
        chk("held_trig_lvl", 32'(level_o), 32'd0);
        trig_i = 1'b0;
        tick();
        chk("trig_low_vld", 32'(valid_o), 32'd0);
        trig_i = 1'b1;
        tick();
        chk("first_cap_lvl", 32'(level_o), 32'd1);
        trig_i = 1'b0;
        pop_chk("first_cap", 8'h10);
        chk("first_pop_vld", 32'(valid_o), 32'd0);

        // Single capture on a ramping counter
        cnt_i = 8'h28; tick();
        cnt_i = 8'h29; tick();
        cnt_i = 8'h2A; trig_i = 1'b1; tick();
        chk("single_vld", 32'(valid_o), 32'd1);
        chk("single_ts",  32'(ts_o),    32'h2A);
        chk("single_lvl", 32'(level_o), 32'd1);
        cnt_i = 8'h2B; trig_i = 1'b0; ready_i = 1'b1; tick();
        ready_i = 1'b0;
        chk("single_pop_vld", 32'(valid_o), 32'd0);
        chk("single_pop_ts",  32'(ts_o),    32'd0);
        chk("single_pop_lvl", 32'(level_o), 32'd0);

        // Fill and overflow
        capture(8'd1);
        capture(8'd3);
        capture(8'd5);
        capture(8'd7);
        chk("fill_lvl", 32'(level_o),    32'd4);
        chk("fill_ovf", 32'(overflow_o), 32'd0);
        cnt_i = 8'd9; trig_i = 1'b1; tick();
        chk("drop_ovf", 32'(overflow_o), 32'd1);
        chk("drop_lvl", 32'(level_o),    32'd4);
        trig_i = 1'b0; tick();
        pop_chk("fifo0", 8'd1);
        pop_chk("fifo1", 8'd3);
        pop_chk("fifo2", 8'd5);
        pop_chk("fifo3", 8'd7);
        chk("fifo_empty_vld", 32'(valid_o),    32'd0);
        chk("fifo_empty_lvl", 32'(level_o),    32'd0);
        chk("ovf_sticky",     32'(overflow_o), 32'd1);

        // Clear colliding with a drop, then a clear alone
        capture(8'h41);
        capture(8'h42);
        capture(8'h43);
        capture(8'h44);
        cnt_i = 8'h45; trig_i = 1'b1; clr_ovf_i = 1'b1; tick();
        chk("clr_collide_ovf", 32'(overflow_o), 32'd1);
        chk("clr_collide_lvl", 32'(level_o),    32'd4);
        trig_i = 1'b0; tick();
        clr_ovf_i = 1'b0;
        chk("clr_alone_ovf", 32'(overflow_o), 32'd0);

        // Full with simultaneous push and pop
        chk("full_head", 32'(ts_o), 32'h41);
        cnt_i = 8'h50; trig_i = 1'b1; ready_i = 1'b1; tick();
        trig_i = 1'b0; ready_i = 1'b0;
        chk("pushpop_lvl", 32'(level_o),    32'd4);
        chk("pushpop_ovf", 32'(overflow_o), 32'd0);
        pop_chk("pp0", 8'h42);
        pop_chk("pp1", 8'h43);
        pop_chk("pp2", 8'h44);
        pop_chk("pp3", 8'h50);
        chk("pp_empty_vld", 32'(valid_o), 32'd0);

        // Counter wrap values stored verbatim
        capture(8'hFF);
        capture(8'h00);
        chk("wrap_lvl", 32'(level_o), 32'd2);
        pop_chk("wrap0", 8'hFF);
        pop_chk("wrap1", 8'h00);

        // Asynchronous reset mid-cycle with two entries stored
        capture(8'h11);
        capture(8'h22);
        chk("pre_rst_lvl", 32'(level_o), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_vld", 32'(valid_o), 32'd0);
        chk("async_rst_lvl", 32'(level_o), 32'd0);
        chk("async_rst_ts",  32'(ts_o),    32'd0);
        tick();
        reset = 1'b1;
        tick();
        capture(8'h33);
        chk("post_rst_lvl", 32'(level_o), 32'd1);
        pop_chk("post_rst", 8'h33);
        chk("post_rst_empty_vld", 32'(valid_o), 32'd0);
        chk("post_rst_empty_lvl", 32'(level_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
